// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage: IsBJ classes, opcodes,
// the NOP encoding and the fetch FSM state codes.
package riscv_pkg;

  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    ISB  = 2'b00,
    ISJ  = 2'b01,
    ISJR = 2'b10,
    NOBJ = 2'b11
  } is_bj_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  // Fetch FSM state codes; S_TRAP only reachable with the misalign trap built in
  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t S_IDLE = 3'd0;
  localparam fetch_state_t S_REQ  = 3'd1;
  localparam fetch_state_t S_WAIT = 3'd2;
  localparam fetch_state_t S_HOLD = 3'd3;
  localparam fetch_state_t S_TRAP = 3'd4;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: imem request/response plus the decode/retire side.
// FETCH_MISALIGN_TRAP_EN adds the fetch_misalign flag.
interface inst_fetch_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc_out;
  logic            inst_ready;
  logic [1:0]      is_bj;
  logic            br_taken;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_tgt;
  logic [31:0]     retire_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fetch_misalign;
`endif

  modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
    output fetch_misalign,
`endif
    output imem_req_valid, imem_addr, inst_valid, inst, pc_out, retire_cnt,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  is_bj, br_taken, pc_imm, jalr_tgt
  );

  modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
    input  fetch_misalign,
`endif
    input  imem_req_valid, imem_addr, inst_valid, inst, pc_out, retire_cnt,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output is_bj, br_taken, pc_imm, jalr_tgt
  );

endinterface

// File: rtl/inst_fetch_next_pc_sel.sv
// Next-PC selection at retirement. Without FETCH_MISALIGN_TRAP_EN the
// low two bits are forced to zero so fetches stay word aligned.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      is_bj,
  input  logic            br_taken,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_imm,
  input  logic [XLEN-1:0] jalr_tgt,
  output logic [XLEN-1:0] next_pc_c
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] tgt;

  assign seq_pc = pc + XLEN'(4);

  always_comb begin
    tgt = seq_pc;
    case (is_bj)
      ISB:     tgt = br_taken ? pc_imm : seq_pc;
      ISJ:     tgt = pc_imm;
      ISJR:    tgt = {jalr_tgt[XLEN-1:1], 1'b0};
      default: tgt = seq_pc;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc_c = tgt;
`else
  assign next_pc_c = {tgt[XLEN-1:2], 2'b00};
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem valid/ready handshake, instruction hold
// and next-PC update on retirement. Optional: FETCH_MISALIGN_TRAP_EN.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  fetch_state_t    state;
  fetch_state_t    state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc_c;
  logic [31:0]     inst_q;
  logic [31:0]     retire_q;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic            retire_c;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .is_bj     (bus.is_bj),
    .br_taken  (bus.br_taken),
    .pc        (pc),
    .pc_imm    (bus.pc_imm),
    .jalr_tgt  (bus.jalr_tgt),
    .next_pc_c (next_pc_c)
  );

  assign retire_c = (state == S_HOLD) && bus.inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; responses and retire strobes only count in their own state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ:  if (bus.imem_req_ready) state_nx = S_WAIT;
      S_WAIT: if (bus.imem_rsp_valid) state_nx = S_HOLD;
      S_HOLD: begin
        if (bus.inst_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_nx = (next_pc_c[1:0] != 2'b00) ? S_TRAP : S_REQ;
`else
          state_nx = S_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_TRAP: state_nx = S_TRAP;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered outputs are loaded from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      inst_q       <= NOP_INST;
      retire_q     <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      req_valid_q  <= (state_nx == S_REQ);
      inst_valid_q <= (state_nx == S_HOLD);
      if ((state == S_WAIT) && bus.imem_rsp_valid) inst_q <= bus.imem_rsp_data;
      if (retire_c) begin
        pc       <= next_pc_c;
        retire_q <= retire_q + 32'd1;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state_nx == S_TRAP);
  end

  assign bus.fetch_misalign = misalign_q;
`endif

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = pc;
  assign bus.pc_out         = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.retire_cnt     = retire_q;

endmodule
